// File: rtl/arq_pkg.sv
// Shared definitions for the ARQ frame sender and the receiver-side CRC checker.
// Holds the state encoding and the CRC-8 (poly 0x07) step function.
package arq_pkg;

  typedef enum logic [1:0] {
    StFill,
    StSend,
    StWaitAck
  } arq_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One byte, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/arq_frame_sender_if.sv
// Client-side and line-side streams plus the receiver ACK/NACK feedback.
// The sender uses the slave modport; the stimulus/line side uses master.
interface arq_frame_sender_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] i_s_data;
  logic              i_s_valid;
  logic              o_s_ready;
  logic [DATA_W-1:0] o_m_data;
  logic              o_m_valid;
  logic              i_m_ready;
  logic              o_m_sof;
  logic              o_m_eof;
  logic              i_ack;
  logic              i_nack;

  modport master (
    output i_s_data, i_s_valid, i_m_ready, i_ack, i_nack,
    input  o_s_ready, o_m_data, o_m_valid, o_m_sof, o_m_eof
  );

  modport slave (
    input  i_s_data, i_s_valid, i_m_ready, i_ack, i_nack,
    output o_s_ready, o_m_data, o_m_valid, o_m_sof, o_m_eof
  );

endinterface

// File: rtl/crc8_gen.sv
// Running CRC-8 over a byte stream. crc shows the value including the byte
// presented this cycle when enable is high, so a caller can latch the final CRC on the last byte.
module crc8_gen
  import arq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data_byte,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] base;

  always_comb begin
    base = clear ? CRC8_INIT : crc_q;
    crc  = enable ? crc8_next(base, data_byte) : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC8_INIT;
    end else if (enable || clear) begin
      crc_q <= crc;
    end
  end

endmodule

// File: rtl/arq_frame_sender.sv
// Packs client beats into FRAME_LEN-beat frames, appends a CRC-8 beat and sends them on
// the line, replaying from the frame buffer on NACK or ACK timeout up to MAX_RETRY times.
module arq_frame_sender
  import arq_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned RETRY_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_arq_en,
  input  logic               i_corrupt_en,
  arq_frame_sender_if.slave  bus,
  output logic [7:0]         o_crc_val,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic               o_send_complete,
  output logic               o_frame_drop
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  arq_state_e        state_q;
  logic [DATA_W-1:0] frame_buf_q [FRAME_LEN];
  logic [IDX_W-1:0]  wr_idx_q;
  logic [CNT_W-1:0]  rd_idx_q;
  logic [TMR_W-1:0]  timer_q;
  logic              corrupt_q;
  logic              s_ready_q, m_valid_q, m_sof_q, m_eof_q;
  logic [DATA_W-1:0] m_data_q;

  logic              accept, last_accept, tx_fire;
  logic [7:0]        crc_run;
  logic [DATA_W-1:0] crc_beat;

  assign accept      = s_ready_q && bus.i_s_valid;
  assign last_accept = accept && (wr_idx_q == IDX_W'(FRAME_LEN - 1));
  assign tx_fire     = m_valid_q && bus.i_m_ready;
  assign crc_beat    = DATA_W'(o_crc_val ^ {7'b0, corrupt_q});

  assign bus.o_s_ready = s_ready_q;
  assign bus.o_m_valid = m_valid_q;
  assign bus.o_m_sof   = m_sof_q;
  assign bus.o_m_eof   = m_eof_q;
  assign bus.o_m_data  = m_data_q;

  crc8_gen u_crc8_gen (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (accept && (wr_idx_q == '0)),
    .enable    (accept),
    .data_byte (bus.i_s_data[7:0]),
    .crc       (crc_run)
  );

  always_ff @(posedge i_clk) begin
    if (accept) begin
      frame_buf_q[wr_idx_q] <= bus.i_s_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= StFill;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      timer_q         <= '0;
      corrupt_q       <= 1'b0;
      s_ready_q       <= 1'b1;
      m_valid_q       <= 1'b0;
      m_sof_q         <= 1'b0;
      m_eof_q         <= 1'b0;
      m_data_q        <= '0;
      o_crc_val       <= CRC8_INIT;
      o_retry_cnt     <= '0;
      o_send_complete <= 1'b0;
      o_frame_drop    <= 1'b0;
    end else begin
      o_send_complete <= 1'b0;
      o_frame_drop    <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (last_accept) begin
            wr_idx_q  <= '0;
            o_crc_val <= crc_run;
            s_ready_q <= 1'b0;
            corrupt_q <= i_corrupt_en && (o_retry_cnt == '0);
            state_q   <= StSend;
            m_valid_q <= 1'b1;
            m_sof_q   <= 1'b1;
            m_eof_q   <= 1'b0;
            m_data_q  <= frame_buf_q[0];
            rd_idx_q  <= CNT_W'(1);
          end else if (accept) begin
            wr_idx_q <= wr_idx_q + 1'b1;
          end
        end
        StSend: begin
          if (tx_fire) begin
            if (m_eof_q) begin
              m_valid_q <= 1'b0;
              m_eof_q   <= 1'b0;
              if (i_arq_en) begin
                state_q <= StWaitAck;
                timer_q <= '0;
              end else begin
                o_send_complete <= 1'b1;
                state_q         <= StFill;
                s_ready_q       <= 1'b1;
              end
            end else if (rd_idx_q == CNT_W'(FRAME_LEN)) begin
              m_data_q <= crc_beat;
              m_sof_q  <= 1'b0;
              m_eof_q  <= 1'b1;
            end else begin
              m_data_q <= frame_buf_q[rd_idx_q[IDX_W-1:0]];
              m_sof_q  <= 1'b0;
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        StWaitAck: begin
          timer_q <= timer_q + 1'b1;
          // ACK takes priority over both NACK and timeout expiry in the same cycle.
          if (bus.i_ack) begin
            o_send_complete <= 1'b1;
            o_retry_cnt     <= '0;
            state_q         <= StFill;
            s_ready_q       <= 1'b1;
          end else if (bus.i_nack || (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
            if (o_retry_cnt < RETRY_W'(MAX_RETRY)) begin
              o_retry_cnt <= o_retry_cnt + 1'b1;
              corrupt_q   <= 1'b0;
              state_q     <= StSend;
              m_valid_q   <= 1'b1;
              m_sof_q     <= 1'b1;
              m_data_q    <= frame_buf_q[0];
              rd_idx_q    <= CNT_W'(1);
            end else begin
              o_frame_drop <= 1'b1;
              o_retry_cnt  <= '0;
              state_q      <= StFill;
              s_ready_q    <= 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_arq_frame_sender.sv
// Directed bench for arq_frame_sender with FRAME_LEN=9 and the "123456789" CRC-8 vector (0xF4).
module tb_arq_frame_sender;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = 9;
  localparam int unsigned MR = 3;
  localparam int unsigned AT = 16;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arq_en = 1'b0;
  logic          corrupt_en = 1'b0;
  logic [7:0]    crc_val;
  logic [RW-1:0] retry_cnt;
  logic          send_complete;
  logic          frame_drop;

  arq_frame_sender_if #(.DATA_W(DW)) bus ();

  arq_frame_sender #(
    .DATA_W      (DW),
    .FRAME_LEN   (FL),
    .MAX_RETRY   (MR),
    .ACK_TIMEOUT (AT),
    .RETRY_W     (RW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_arq_en        (arq_en),
    .i_corrupt_en    (corrupt_en),
    .bus             (bus),
    .o_crc_val       (crc_val),
    .o_retry_cnt     (retry_cnt),
    .o_send_complete (send_complete),
    .o_frame_drop    (frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    int         cyc;
  } beat_t;

  beat_t      beats [$];
  logic [7:0] msg [FL];
  int         cyc = 0;
  int         n_complete = 0;
  int         n_drop = 0;
  int         n_stab = 0;
  int         errors = 0;
  int         checks = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_sof = 1'b0;
  logic       prev_eof = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so the negedge sees the values the next posedge will use.
  always @(negedge clk) begin
    if (send_complete) n_complete <= n_complete + 1;
    if (frame_drop) n_drop <= n_drop + 1;
    if (prev_stall && rst_n &&
        (!bus.o_m_valid || bus.o_m_data != prev_data ||
         bus.o_m_sof != prev_sof || bus.o_m_eof != prev_eof)) begin
      n_stab <= n_stab + 1;
    end
    prev_stall <= bus.o_m_valid && !bus.i_m_ready;
    prev_data  <= bus.o_m_data;
    prev_sof   <= bus.o_m_sof;
    prev_eof   <= bus.o_m_eof;
    if (bus.o_m_valid && bus.i_m_ready) begin
      beats.push_back('{bus.o_m_data, bus.o_m_sof, bus.o_m_eof, cyc});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame();
    int w;
    for (int i = 0; i < FL; i++) begin
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = msg[i];
      w = 0;
      while (!bus.o_s_ready && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) check("s_ready_wait", 32'(bus.o_s_ready), 32'd1);
      tick();
    end
    bus.i_s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int w;
    w = 0;
    while (beats.size() < n && w < 400) begin
      tick();
      w++;
    end
    check(tag, beats.size(), n);
  endtask

  task automatic check_frame(input int base, input logic [7:0] crc_exp, input string tag);
    for (int i = 0; i <= FL; i++) begin
      if (base + i < beats.size()) begin
        check($sformatf("%s_data%0d", tag, i), beats[base+i].data,
              (i < FL) ? msg[i] : crc_exp);
        check($sformatf("%s_sofeof%0d", tag, i), {beats[base+i].sof, beats[base+i].eof},
              {(i == 0), (i == FL)});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int base, c0, d0, w;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    bus.i_s_data  = '0;
    bus.i_s_valid = 1'b0;
    bus.i_m_ready = 1'b1;
    bus.i_ack     = 1'b0;
    bus.i_nack    = 1'b0;

    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_s_ready", 32'(bus.o_s_ready), 32'd1);
    check("rst_m_valid", 32'(bus.o_m_valid), 32'd0);
    check("rst_sof_eof", {bus.o_m_sof, bus.o_m_eof}, 2'b00);
    check("rst_crc", crc_val, 8'h00);
    check("rst_retry", retry_cnt, 0);
    check("rst_pulses", {send_complete, frame_drop}, 2'b00);

    // Fire-and-forget frame.
    arq_en = 1'b0;
    base = beats.size();
    c0 = n_complete;
    send_frame();
    wait_beats(base + 10, "a_beats");
    check_frame(base, 8'hF4, "a");
    tick(2);
    check("a_crc_val", crc_val, 8'hF4);
    check("a_complete", n_complete - c0, 1);
    check("a_s_ready", 32'(bus.o_s_ready), 32'd1);

    // Corrupted first send, NACK 5 cycles after eof, clean retransmission, then ACK.
    arq_en = 1'b1;
    corrupt_en = 1'b1;
    base = beats.size();
    send_frame();
    wait_beats(base + 10, "b_beats1");
    check("b_crc_first", beats[base+9].data, 8'hF5);
    tick(4);
    bus.i_nack = 1'b1;
    tick();
    bus.i_nack = 1'b0;
    wait_beats(base + 20, "b_beats2");
    check_frame(base + 10, 8'hF4, "b_retx");
    check("b_retry", retry_cnt, 1);
    tick(2);
    c0 = n_complete;
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    tick(2);
    check("b_complete", n_complete - c0, 1);
    check("b_retry_clr", retry_cnt, 0);
    check("b_s_ready", 32'(bus.o_s_ready), 32'd1);
    corrupt_en = 1'b0;

    // No ACK: four transmissions spaced by the timeout, then a drop.
    base = beats.size();
    c0 = n_complete;
    d0 = n_drop;
    send_frame();
    wait_beats(base + 31, "c_beats4");
    check("c_retry3", retry_cnt, 3);
    w = 0;
    while (n_drop == d0 && w < 500) begin
      tick();
      w++;
    end
    check("c_drop", n_drop - d0, 1);
    check("c_beats", beats.size() - base, 40);
    for (int k = 0; k < 4; k++) begin
      if (base + 10 * k + 9 < beats.size()) begin
        check($sformatf("c_crc%0d", k), beats[base+10*k+9].data, 8'hF4);
        if (k > 0) check($sformatf("c_gap%0d", k),
                         beats[base+10*k].cyc - beats[base+10*k-1].cyc, AT + 1);
      end
    end
    tick();
    check("c_s_ready", 32'(bus.o_s_ready), 32'd1);
    check("c_retry_clr", retry_cnt, 0);
    tick(30);
    check("c_no_more", beats.size() - base, 40);
    check("c_no_complete", n_complete - c0, 0);

    // Random line backpressure.
    arq_en = 1'b0;
    bus.i_m_ready = 1'b0;
    base = beats.size();
    send_frame();
    w = 0;
    while (beats.size() < base + 10 && w < 300) begin
      bus.i_m_ready = 1'($urandom_range(0, 1));
      tick();
      w++;
    end
    check("d_beats", beats.size(), base + 10);
    check_frame(base, 8'hF4, "d");
    check("d_stable", n_stab, 0);
    bus.i_m_ready = 1'b1;
    tick(3);

    // ACK and NACK together: ACK wins.
    arq_en = 1'b1;
    base = beats.size();
    c0 = n_complete;
    d0 = n_drop;
    send_frame();
    wait_beats(base + 10, "e_beats");
    tick(2);
    bus.i_ack  = 1'b1;
    bus.i_nack = 1'b1;
    tick();
    bus.i_ack  = 1'b0;
    bus.i_nack = 1'b0;
    tick(25);
    check("e_complete", n_complete - c0, 1);
    check("e_no_retx", beats.size(), base + 10);
    check("e_retry", retry_cnt, 0);
    check("e_no_drop", n_drop - d0, 0);

    // Stray ACK while filling.
    base = beats.size();
    c0 = n_complete;
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    tick(3);
    check("f_no_complete", n_complete - c0, 0);
    check("f_s_ready", 32'(bus.o_s_ready), 32'd1);
    check("f_no_beats", beats.size(), base);

    // Reset in the middle of a stalled retransmission.
    base = beats.size();
    c0 = n_complete;
    d0 = n_drop;
    send_frame();
    wait_beats(base + 10, "g_beats");
    tick(2);
    bus.i_nack = 1'b1;
    tick();
    bus.i_nack = 1'b0;
    bus.i_m_ready = 1'b0;
    tick(3);
    check("g_valid_pre", 32'(bus.o_m_valid), 32'd1);
    check("g_retry_pre", retry_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("g_valid_async", 32'(bus.o_m_valid), 32'd0);
    check("g_retry_rst", retry_cnt, 0);
    check("g_crc_rst", crc_val, 8'h00);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_m_ready = 1'b1;
    tick();
    check("g_s_ready", 32'(bus.o_s_ready), 32'd1);
    check("g_retry", retry_cnt, 0);
    tick(20);
    check("g_no_pulses", {n_complete - c0, n_drop - d0}, 64'd0);
    check("g_no_beats", beats.size(), base + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
